// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg : shared encodings and counter widths for the arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  localparam int c_LAT_W    = 2;
  localparam int c_STARVE_W = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  typedef enum logic [0:0] {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_port_arbiter_if : fetch/data request ports plus the shared SRAM port
// Rev 1.0
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_cancel;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  modport slave (
    input  inst_req, inst_addr, inst_cancel,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output sram_en, sram_wen, sram_addr, sram_wdata,
    input  sram_rdata
  );

  modport master (
    output inst_req, inst_addr, inst_cancel,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  sram_en, sram_wen, sram_addr, sram_wdata,
    output sram_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_arb_tracker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arb_tracker : in-flight transaction state (owner, latency, drop) and
//                   response-valid decode
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_arb_tracker
  import mem_port_arbiter_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic   clk,
  input  logic   resetn,
  input  logic   grant,
  input  owner_t grant_owner,
  input  logic   grant_wr,
  input  logic   inst_cancel,
  output logic   can_grant,
  output logic   inst_resp,
  output logic   data_resp,
  output logic   resp_rd
);

  state_t             r_state;
  state_t             w_state_next;
  logic [c_LAT_W-1:0] r_lat_cnt;
  owner_t             r_owner;
  logic               r_wr;
  logic               r_drop;
  logic               w_last;

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  // Outputs gated by resetn so nothing leaks while reset is held.
  always_comb begin
    w_state_next = r_state;
    w_last       = (r_state == ST_BUSY) && (r_lat_cnt == c_LAT_W'(1));
    can_grant    = resetn && ((r_state == ST_IDLE) || w_last);
    inst_resp    = resetn && w_last && (r_owner == OWN_INST) && !r_drop;
    data_resp    = resetn && w_last && (r_owner == OWN_DATA);
    resp_rd      = !r_wr;
    case (r_state)
      ST_IDLE: if (grant) w_state_next = ST_BUSY;
      ST_BUSY: if (w_last && !grant) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_lat_cnt <= '0;
      r_owner   <= OWN_INST;
      r_wr      <= 1'b0;
      r_drop    <= 1'b0;
    end else if (grant) begin
      r_lat_cnt <= c_LAT_W'(RD_LATENCY);
      r_owner   <= grant_owner;
      r_wr      <= grant_wr;
      r_drop    <= 1'b0;
    end else if (r_state == ST_BUSY) begin
      r_lat_cnt <= r_lat_cnt - c_LAT_W'(1);
      if ((r_owner == OWN_INST) && inst_cancel) r_drop <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_port_arbiter : shares one single-port SRAM between fetch and data,
//                    data first with a starvation bound for fetch
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               resetn,
  mem_port_arbiter_if.slave bus
);

  logic                  w_can_grant;
  logic                  w_inst_starved;
  logic                  w_grant_data;
  logic                  w_grant_inst;
  logic                  w_grant;
  owner_t                w_owner;
  logic                  w_inst_resp;
  logic                  w_data_resp;
  logic                  w_resp_rd;
  logic [c_STARVE_W-1:0] r_starve_cnt;

  always_comb begin
    w_inst_starved = bus.inst_req && (r_starve_cnt == c_STARVE_W'(STARVE_LIMIT));
    w_grant_data   = w_can_grant && bus.data_req && !w_inst_starved;
    w_grant_inst   = w_can_grant && !w_grant_data && bus.inst_req && !bus.inst_cancel;
    w_grant        = w_grant_data || w_grant_inst;
    w_owner        = w_grant_data ? OWN_DATA : OWN_INST;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_starve_cnt <= '0;
    end else if (!bus.inst_req || w_grant_inst) begin
      r_starve_cnt <= '0;
    end else if (w_grant_data && (r_starve_cnt != c_STARVE_W'(STARVE_LIMIT))) begin
      r_starve_cnt <= r_starve_cnt + c_STARVE_W'(1);
    end
  end

  mem_arb_tracker #(
    .RD_LATENCY (RD_LATENCY)
  ) u_tracker (
    .clk         (clk),
    .resetn      (resetn),
    .grant       (w_grant),
    .grant_owner (w_owner),
    .grant_wr    (bus.data_wr),
    .inst_cancel (bus.inst_cancel),
    .can_grant   (w_can_grant),
    .inst_resp   (w_inst_resp),
    .data_resp   (w_data_resp),
    .resp_rd     (w_resp_rd)
  );

  assign bus.inst_addr_ok = w_grant_inst;
  assign bus.data_addr_ok = w_grant_data;

  assign bus.sram_en    = w_grant;
  assign bus.sram_wen   = (w_grant_data && bus.data_wr) ? bus.data_wstrb : 4'h0;
  assign bus.sram_addr  = w_grant_data ? bus.data_addr  :
                          w_grant_inst ? bus.inst_addr  : 32'h0;
  assign bus.sram_wdata = w_grant_data ? bus.data_wdata : 32'h0;

  // Writes complete with zero read data.
  assign bus.inst_data_ok = w_inst_resp;
  assign bus.inst_rdata   = w_inst_resp ? bus.sram_rdata : 32'h0;
  assign bus.data_data_ok = w_data_resp;
  assign bus.data_rdata   = (w_data_resp && w_resp_rd) ? bus.sram_rdata : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter : directed checks on a latency-1 and a latency-3 arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  mem_port_arbiter_if ifa ();
  mem_port_arbiter_if ifb ();

  mem_port_arbiter #(.RD_LATENCY(1), .STARVE_LIMIT(4)) u_dut_a (
    .clk    (clk),
    .resetn (resetn),
    .bus    (ifa)
  );

  mem_port_arbiter #(.RD_LATENCY(3), .STARVE_LIMIT(4)) u_dut_b (
    .clk    (clk),
    .resetn (resetn),
    .bus    (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    ifa.inst_req = 0; ifa.inst_addr = 0; ifa.inst_cancel = 0;
    ifa.data_req = 0; ifa.data_wr = 0; ifa.data_wstrb = 0;
    ifa.data_addr = 0; ifa.data_wdata = 0; ifa.sram_rdata = 0;
    ifb.inst_req = 0; ifb.inst_addr = 0; ifb.inst_cancel = 0;
    ifb.data_req = 0; ifb.data_wr = 0; ifb.data_wstrb = 0;
    ifb.data_addr = 0; ifb.data_wdata = 0; ifb.sram_rdata = 0;

    // Reset state
    repeat (2) next_cycle();
    #1;
    chk1 ("rst_inst_addr_ok", ifa.inst_addr_ok, 1'b0);
    chk1 ("rst_data_addr_ok", ifa.data_addr_ok, 1'b0);
    chk1 ("rst_inst_data_ok", ifa.inst_data_ok, 1'b0);
    chk1 ("rst_data_data_ok", ifa.data_data_ok, 1'b0);
    chk1 ("rst_sram_en", ifa.sram_en, 1'b0);
    chk32("rst_sram_wen", {28'h0, ifa.sram_wen}, 32'h0);
    chk32("rst_sram_addr", ifa.sram_addr, 32'h0);
    chk32("rst_sram_wdata", ifa.sram_wdata, 32'h0);
    next_cycle();
    resetn = 1'b1;

    // 1: lone fetch
    next_cycle();
    ifa.inst_req = 1; ifa.inst_addr = 32'hBFC0_0000;
    #1;
    chk1 ("t1_inst_addr_ok", ifa.inst_addr_ok, 1'b1);
    chk1 ("t1_sram_en", ifa.sram_en, 1'b1);
    chk32("t1_sram_wen", {28'h0, ifa.sram_wen}, 32'h0);
    chk32("t1_sram_addr", ifa.sram_addr, 32'hBFC0_0000);
    chk1 ("t1_inst_data_ok_early", ifa.inst_data_ok, 1'b0);
    next_cycle();
    ifa.inst_req = 0; ifa.sram_rdata = 32'h3C08_BFC0;
    #1;
    chk1 ("t1_inst_data_ok", ifa.inst_data_ok, 1'b1);
    chk32("t1_inst_rdata", ifa.inst_rdata, 32'h3C08_BFC0);
    chk32("t1_data_rdata", ifa.data_rdata, 32'h0);
    chk1 ("t1_no_grant", ifa.sram_en, 1'b0);

    // 2: simultaneous fetch and data read
    next_cycle();
    ifa.inst_req = 1; ifa.inst_addr = 32'hBFC0_0004;
    ifa.data_req = 1; ifa.data_wr = 0; ifa.data_addr = 32'h0000_1000;
    ifa.sram_rdata = 32'h0;
    #1;
    chk1 ("t2_data_addr_ok", ifa.data_addr_ok, 1'b1);
    chk1 ("t2_inst_addr_ok_blocked", ifa.inst_addr_ok, 1'b0);
    chk32("t2_sram_addr_data", ifa.sram_addr, 32'h0000_1000);
    next_cycle();
    ifa.data_req = 0; ifa.sram_rdata = 32'hDEAD_BEEF;
    #1;
    chk1 ("t2_data_data_ok", ifa.data_data_ok, 1'b1);
    chk32("t2_data_rdata", ifa.data_rdata, 32'hDEAD_BEEF);
    chk32("t2_inst_rdata_zero", ifa.inst_rdata, 32'h0);
    chk1 ("t2_inst_addr_ok", ifa.inst_addr_ok, 1'b1);
    chk32("t2_sram_addr_inst", ifa.sram_addr, 32'hBFC0_0004);
    next_cycle();
    ifa.inst_req = 0; ifa.sram_rdata = 32'h1234_5678;
    #1;
    chk1 ("t2_inst_data_ok", ifa.inst_data_ok, 1'b1);
    chk32("t2_inst_rdata", ifa.inst_rdata, 32'h1234_5678);
    chk1 ("t2_data_data_ok_clear", ifa.data_data_ok, 1'b0);

    // 3: starvation bound, grants D D D D I D
    next_cycle();
    ifa.inst_req = 1; ifa.inst_addr = 32'hBFC0_0008;
    ifa.data_req = 1; ifa.data_addr = 32'h0000_3000;
    ifa.sram_rdata = 32'h0;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) next_cycle();
      #1;
      chk1 ($sformatf("t3_data_addr_ok_%0d", k), ifa.data_addr_ok, k != 5);
      chk1 ($sformatf("t3_inst_addr_ok_%0d", k), ifa.inst_addr_ok, k == 5);
      if (k > 1) begin
        chk1 ($sformatf("t3_data_data_ok_%0d", k), ifa.data_data_ok, k != 6);
        chk1 ($sformatf("t3_inst_data_ok_%0d", k), ifa.inst_data_ok, k == 6);
      end
    end
    next_cycle();
    ifa.inst_req = 0; ifa.data_req = 0;
    #1;
    chk1 ("t3_last_data_data_ok", ifa.data_data_ok, 1'b1);
    chk1 ("t3_idle", ifa.sram_en, 1'b0);

    // 4: byte-strobed write
    next_cycle();
    ifa.data_req = 1; ifa.data_wr = 1; ifa.data_wstrb = 4'b0011;
    ifa.data_addr = 32'h0000_2004; ifa.data_wdata = 32'h0000_A5A5;
    #1;
    chk1 ("t4_data_addr_ok", ifa.data_addr_ok, 1'b1);
    chk32("t4_sram_wen", {28'h0, ifa.sram_wen}, 32'h3);
    chk32("t4_sram_addr", ifa.sram_addr, 32'h0000_2004);
    chk32("t4_sram_wdata", ifa.sram_wdata, 32'h0000_A5A5);
    next_cycle();
    ifa.data_req = 0; ifa.data_wr = 0; ifa.data_wstrb = 0;
    ifa.sram_rdata = 32'hFFFF_FFFF;
    #1;
    chk1 ("t4_data_data_ok", ifa.data_data_ok, 1'b1);
    chk32("t4_data_rdata_zero", ifa.data_rdata, 32'h0);

    // 6: reset in the middle of a fetch
    next_cycle();
    ifa.inst_req = 1; ifa.inst_addr = 32'hBFC0_0010;
    #1;
    chk1 ("t6_inst_addr_ok", ifa.inst_addr_ok, 1'b1);
    next_cycle();
    resetn = 1'b0; ifa.sram_rdata = 32'hCAFE_F00D;
    #1;
    chk1 ("t6_rst_inst_data_ok", ifa.inst_data_ok, 1'b0);
    chk1 ("t6_rst_inst_addr_ok", ifa.inst_addr_ok, 1'b0);
    chk1 ("t6_rst_sram_en", ifa.sram_en, 1'b0);
    chk32("t6_rst_sram_addr", ifa.sram_addr, 32'h0);
    next_cycle();
    resetn = 1'b1;
    #1;
    chk1 ("t6_post_inst_data_ok", ifa.inst_data_ok, 1'b0);
    chk1 ("t6_post_inst_addr_ok", ifa.inst_addr_ok, 1'b1);
    next_cycle();
    ifa.inst_req = 0;
    #1;
    chk1 ("t6_post_resp", ifa.inst_data_ok, 1'b1);
    chk32("t6_post_rdata", ifa.inst_rdata, 32'hCAFE_F00D);

    // Latency-3 baseline fetch
    next_cycle();
    ifb.inst_req = 1; ifb.inst_addr = 32'hBFC0_0020;
    #1;
    chk1 ("l3_inst_addr_ok", ifb.inst_addr_ok, 1'b1);
    next_cycle();
    ifb.inst_req = 0;
    #1;
    chk1 ("l3_resp_t1", ifb.inst_data_ok, 1'b0);
    next_cycle();
    #1;
    chk1 ("l3_resp_t2", ifb.inst_data_ok, 1'b0);
    next_cycle();
    ifb.sram_rdata = 32'h0BAD_CAFE;
    #1;
    chk1 ("l3_resp_t3", ifb.inst_data_ok, 1'b1);
    chk32("l3_rdata", ifb.inst_rdata, 32'h0BAD_CAFE);

    // 5: cancel an in-flight fetch, data still granted in the response slot
    next_cycle();
    ifb.inst_req = 1; ifb.inst_addr = 32'hBFC0_0024; ifb.sram_rdata = 32'h0;
    #1;
    chk1 ("t5_inst_addr_ok", ifb.inst_addr_ok, 1'b1);
    next_cycle();
    ifb.inst_req = 0; ifb.inst_cancel = 1;
    #1;
    chk1 ("t5_busy_no_grant", ifb.sram_en, 1'b0);
    next_cycle();
    ifb.inst_cancel = 0;
    #1;
    chk1 ("t5_inst_data_ok_t2", ifb.inst_data_ok, 1'b0);
    next_cycle();
    ifb.data_req = 1; ifb.data_addr = 32'h0000_4000; ifb.sram_rdata = 32'h1111_2222;
    #1;
    chk1 ("t5_inst_dropped", ifb.inst_data_ok, 1'b0);
    chk1 ("t5_data_addr_ok", ifb.data_addr_ok, 1'b1);
    chk32("t5_sram_addr", ifb.sram_addr, 32'h0000_4000);
    next_cycle();
    ifb.data_req = 0;
    #1;
    chk1 ("t5_data_early_1", ifb.data_data_ok, 1'b0);
    next_cycle();
    #1;
    chk1 ("t5_data_early_2", ifb.data_data_ok, 1'b0);
    next_cycle();
    ifb.sram_rdata = 32'h3333_4444;
    #1;
    chk1 ("t5_data_data_ok", ifb.data_data_ok, 1'b1);
    chk32("t5_data_rdata", ifb.data_rdata, 32'h3333_4444);

    next_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
